// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues D-stage predictions in order, compares the oldest
// entry against the E-stage outcome to drive redirect/flush, emits an M-stage
// predictor update record and keeps prediction-accuracy counters.
module branch_resolve_unit #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchD,
    input  logic             stallD,
    input  logic             pred_takeD,
    input  logic [31:0]      pcD,
    input  logic [31:0]      targetD,
    input  logic             resolveE,
    input  logic             actual_takeE,
    output logic             mispredE,
    output logic [31:0]      redirect_pcE,
    output logic             flushD,
    output logic             flushE,
    output logic             upd_validM,
    output logic [31:0]      upd_pcM,
    output logic             upd_takenM,
    output logic             q_full,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] FullCnt = (PW+1)'(QDEPTH);

    typedef enum logic [0:0] {StNormal, StRecover} state_e;

    state_e state_q, state_d;

    logic [31:0] pc_mem  [QDEPTH];
    logic [31:0] tgt_mem [QDEPTH];
    logic        pred_mem[QDEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] mp_q, mp_d;

    logic empty, full, pop, push_req, push, push_en;
    logic head_pred;
    logic [31:0] head_pc, head_tgt;

    // Head compare and redirect target, resolved in the same cycle as resolveE
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FullCnt);
        head_pc   = pc_mem[rd_ptr_q];
        head_tgt  = tgt_mem[rd_ptr_q];
        head_pred = pred_mem[rd_ptr_q];
        pop       = resolveE & ~empty;
        mispredE  = pop & (actual_takeE != head_pred);
        redirect_pcE = '0;
        if (mispredE) begin
            redirect_pcE = actual_takeE ? head_tgt : head_pc + 32'd4;
        end
        push_req = branchD & ~stallD & push_en & ~mispredE;
        // A pop in the same cycle frees the slot, so push is legal when full
        push     = push_req & (~full | pop);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StNormal;
        else     state_q <= state_d;
    end

    // FSM next state: one recovery cycle after every mispredict
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNormal:  if (mispredE) state_d = StRecover;
            StRecover: state_d = StNormal;
            default:   state_d = StNormal;
        endcase
    end

    // FSM outputs: D holds a flushed slot during recovery, so no pushes
    always_comb begin
        push_en = (state_q == StNormal);
    end

    // Queue storage; contents are only meaningful below count_q, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= pcD;
            tgt_mem[wr_ptr_q]  <= targetD;
            pred_mem[wr_ptr_q] <= pred_takeD;
        end
    end

    // Next-state for pointers, count, update record, flags and counters
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        upd_valid_d = pop;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        ovf_d       = ovf_q | (push_req & full & ~pop);
        unf_d       = unf_q | (resolveE & empty);
        br_d        = br_q;
        mp_d        = mp_q;
        if (mispredE) begin
            // Everything still queued is younger and on the wrong path
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        if (pop) begin
            upd_pc_d    = head_pc;
            upd_taken_d = actual_takeE;
            if (br_q != '1) br_d = br_q + 1'b1;
            if (mispredE && mp_q != '1) mp_d = mp_q + 1'b1;
        end
    end

    // Registered state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            br_q        <= '0;
            mp_q        <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            br_q        <= br_d;
            mp_q        <= mp_d;
        end
    end

    // Output wiring
    always_comb begin
        flushD        = mispredE;
        flushE        = mispredE;
        upd_validM    = upd_valid_q;
        upd_pcM       = upd_pc_q;
        upd_takenM    = upd_taken_q;
        q_full        = full;
        err_overflow  = ovf_q;
        err_underflow = unf_q;
        br_count      = br_q;
        mp_count      = mp_q;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int unsigned QD = 4;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          branchD, stallD, pred_takeD, resolveE, actual_takeE;
    logic [31:0]   pcD, targetD;
    logic          mispredE, flushD, flushE, upd_validM, upd_takenM;
    logic [31:0]   redirect_pcE, upd_pcM;
    logic          q_full, err_overflow, err_underflow;
    logic [CW-1:0] br_count, mp_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(.QDEPTH(QD), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .branchD      (branchD),
        .stallD       (stallD),
        .pred_takeD   (pred_takeD),
        .pcD          (pcD),
        .targetD      (targetD),
        .resolveE     (resolveE),
        .actual_takeE (actual_takeE),
        .mispredE     (mispredE),
        .redirect_pcE (redirect_pcE),
        .flushD       (flushD),
        .flushE       (flushE),
        .upd_validM   (upd_validM),
        .upd_pcM      (upd_pcM),
        .upd_takenM   (upd_takenM),
        .q_full       (q_full),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow),
        .br_count     (br_count),
        .mp_count     (mp_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
    } ent_t;

    // Reference model state
    ent_t          mq[$];
    bit            m_rec;
    bit            m_uv;
    logic [31:0]   m_upc;
    bit            m_ut;
    bit            m_ovf, m_unf;
    logic [CW-1:0] m_br, m_mp;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rec = 0; m_uv = 0; m_upc = '0; m_ut = 0;
        m_ovf = 0; m_unf = 0; m_br = '0; m_mp = '0;
    endtask

    task automatic check_reg();
        check_eq("upd_validM", upd_validM, m_uv);
        check_eq("upd_pcM", upd_pcM, m_upc);
        check_eq("upd_takenM", upd_takenM, m_ut);
        check_eq("q_full", q_full, mq.size() == QD);
        check_eq("err_overflow", err_overflow, m_ovf);
        check_eq("err_underflow", err_underflow, m_unf);
        check_eq("br_count", br_count, m_br);
        check_eq("mp_count", mp_count, m_mp);
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1
    task automatic cycle();
        bit          pop, misp, preq;
        ent_t        h;
        logic [31:0] redir;
        #2;
        pop   = resolveE && mq.size() != 0;
        h     = pop ? mq[0] : '0;
        misp  = pop && (actual_takeE != h.pred);
        redir = !misp ? 32'h0 : (actual_takeE ? h.tgt : h.pc + 32'd4);
        preq  = branchD && !stallD && !m_rec && !misp;
        check_eq("mispredE", mispredE, misp);
        check_eq("flushD", flushD, misp);
        check_eq("flushE", flushE, misp);
        check_eq("redirect_pcE", redirect_pcE, redir);
        @(posedge clk);
        #1;
        if (resolveE && mq.size() == 0) m_unf = 1;
        m_uv = pop;
        if (pop) begin
            m_upc = h.pc;
            m_ut  = actual_takeE;
            if (m_br != '1) m_br++;
            if (misp && m_mp != '1) m_mp++;
            void'(mq.pop_front());
        end
        if (misp) mq.delete();
        else if (preq) begin
            if (mq.size() < QD) mq.push_back('{pc: pcD, tgt: targetD, pred: pred_takeD});
            else m_ovf = 1;
        end
        m_rec = misp;
        check_reg();
    endtask

    task automatic drv(input bit b, input bit st, input bit pr, input logic [31:0] pc,
                       input logic [31:0] tg, input bit rs, input bit ac);
        branchD = b; stallD = st; pred_takeD = pr; pcD = pc; targetD = tg;
        resolveE = rs; actual_takeE = ac;
        cycle();
    endtask

    task automatic idle();
        drv(0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_mispredE", mispredE, 0);
        check_eq("rst_flushD", flushD, 0);
        check_eq("rst_flushE", flushE, 0);
        check_eq("rst_redirect", redirect_pcE, 0);
        check_reg();
        branchD = 0; stallD = 0; pred_takeD = 0; pcD = 0; targetD = 0;
        resolveE = 0; actual_takeE = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        branchD = 0; stallD = 0; pred_takeD = 0; pcD = 0; targetD = 0;
        resolveE = 1; actual_takeE = 1;
        model_reset();
        #2;
        check_eq("init_mispredE", mispredE, 0);
        check_eq("init_redirect", redirect_pcE, 0);
        check_reg();
        resolveE = 0; actual_takeE = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // In-order flow with correct predictions
        drv(1, 0, 1, 32'h100, 32'h180, 0, 0);
        drv(1, 0, 0, 32'h200, 32'h280, 1, 1);
        drv(0, 0, 0, 32'h0, 32'h0, 1, 0);
        idle();

        // Taken-predicted branch that falls through; push during recovery ignored
        async_reset();
        drv(1, 0, 1, 32'h40, 32'h80, 0, 0);
        drv(0, 0, 0, 32'h0, 32'h0, 1, 0);
        drv(1, 0, 1, 32'h500, 32'h600, 0, 0);
        drv(0, 0, 0, 32'h0, 32'h0, 1, 1);

        // Mispredict flushes younger entries and a same-cycle push
        async_reset();
        drv(1, 0, 0, 32'h2F0, 32'h300, 0, 0);
        drv(1, 0, 1, 32'h310, 32'h400, 0, 0);
        drv(1, 0, 1, 32'h320, 32'h410, 0, 0);
        drv(1, 0, 1, 32'h700, 32'h800, 1, 1);
        idle();
        drv(0, 0, 0, 32'h0, 32'h0, 1, 1);

        // Fill, overflow, then push+pop across pointer wrap
        async_reset();
        for (int i = 0; i < 4; i++) drv(1, 0, 1, 32'h1000 + 32'(i) * 16, 32'h9000, 0, 0);
        drv(1, 0, 1, 32'h2000, 32'h9000, 0, 0);
        for (int i = 0; i < 8; i++) drv(1, 0, 1, 32'h3000 + 32'(i) * 16, 32'h9000, 1, 1);
        for (int i = 0; i < 4; i++) drv(0, 0, 0, 32'h0, 32'h0, 1, 1);

        // pc+4 wraps to zero
        async_reset();
        drv(1, 0, 1, 32'hFFFF_FFFC, 32'h1234, 0, 0);
        drv(0, 0, 0, 32'h0, 32'h0, 1, 0);
        idle();

        // Reset mid-run with entries queued and counters nonzero
        async_reset();
        drv(1, 0, 1, 32'h600, 32'h700, 0, 0);
        drv(1, 0, 1, 32'h610, 32'h710, 1, 1);
        drv(1, 0, 0, 32'h620, 32'h720, 0, 0);
        async_reset();
        drv(0, 0, 0, 32'h0, 32'h0, 1, 1);

        // Random traffic
        async_reset();
        for (int i = 0; i < 500; i++) begin
            drv($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 1, {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC,
                $urandom(), $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
